// File: rtl/measure_pkg.sv
// Shared types for the measure unit arithmetic blocks.
package measure_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE,
        SUB_SUB,
        SUB_NEG,
        SUB_DONE
    } sub_state_e;

    localparam int SEG_W_DEFAULT = 16;
    localparam int WIDTH_DEFAULT = 32;

endpackage

// File: rtl/multi_cycle_sub_seg_sub.sv
// One segment of the subtractor: d = a - b - bin, combinational, with borrow out.
module seg_sub #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             bin_i,
    output logic [SEG_W-1:0] d_o,
    output logic             bout_o
);

    logic [SEG_W:0] full;

    // One extra bit: the result never exceeds 2^SEG_W in magnitude, so the top bit is the borrow.
    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{SEG_W{1'b0}}, bin_i};
    assign d_o    = full[SEG_W-1:0];
    assign bout_o = full[SEG_W];

endmodule

// File: rtl/multi_cycle_sub.sv
// Segmented a-b (optionally |a-b|), one SEG_W slice per cycle, LSB first; NSEG or 2*NSEG cycles to valid_o.
// Accepts only when idle; result and sign are held in DONE until ready_i.
module multi_cycle_sub
    import measure_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SEG_W = SEG_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abs_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             neg_o
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             abs_q, abs_d;
    logic             neg_q, neg_d;
    logic             borrow_q, borrow_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_d;
    logic             seg_bout;
    logic             last_seg;

    assign last_seg = (idx_q == LAST_IDX);

    // SUB uses the operand slices; NEG reuses the same unit as 0 - diff slice.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        case (state_q)
            SUB_SUB: begin
                seg_a = a_q[idx_q*SEG_W +: SEG_W];
                seg_b = b_q[idx_q*SEG_W +: SEG_W];
            end
            SUB_NEG: begin
                seg_b = diff_q[idx_q*SEG_W +: SEG_W];
            end
            default: ;
        endcase
    end

    seg_sub #(
        .SEG_W (SEG_W)
    ) u_seg_sub (
        .a_i    (seg_a),
        .b_i    (seg_b),
        .bin_i  (borrow_q),
        .d_o    (seg_d),
        .bout_o (seg_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        abs_d    = abs_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        borrow_d = borrow_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        case (state_q)
            SUB_IDLE: begin
                if (valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    abs_d    = abs_i;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = SUB_SUB;
                end
            end
            SUB_SUB: begin
                diff_d[idx_q*SEG_W +: SEG_W] = seg_d;
                borrow_d = seg_bout;
                idx_d    = idx_q + 1'b1;
                if (last_seg) begin
                    neg_d = seg_bout;
                    idx_d = '0;
                    if (abs_q && seg_bout) begin
                        borrow_d = 1'b0;
                        state_d  = SUB_NEG;
                    end else begin
                        valid_d = 1'b1;
                        state_d = SUB_DONE;
                    end
                end
            end
            SUB_NEG: begin
                diff_d[idx_q*SEG_W +: SEG_W] = seg_d;
                borrow_d = seg_bout;
                idx_d    = idx_q + 1'b1;
                if (last_seg) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = SUB_DONE;
                end
            end
            SUB_DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = SUB_IDLE;
                end
            end
            default: state_d = SUB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SUB_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            abs_q    <= 1'b0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            borrow_q <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            abs_q    <= abs_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            borrow_q <= borrow_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
        end
    end

    assign ready_o = (state_q == SUB_IDLE);
    assign valid_o = valid_q;
    assign diff_o  = diff_q;
    assign neg_o   = neg_q;

endmodule

// File: tb/tb_multi_cycle_sub.sv
// Directed and randomised checks of multi_cycle_sub at three width/segment configurations.
module tb_multi_cycle_sub;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: WIDTH=32, SEG_W=16
    logic        valid_i, ready_o, abs_i, valid_o, ready_i, neg_o;
    logic [31:0] a_i, b_i, diff_o;

    multi_cycle_sub #(.WIDTH(32), .SEG_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .abs_i(abs_i), .valid_o(valid_o),
        .ready_i(ready_i), .diff_o(diff_o), .neg_o(neg_o)
    );

    // WIDTH=32, SEG_W=8
    logic        s8_valid_i, s8_ready_o, s8_abs_i, s8_valid_o, s8_ready_i, s8_neg_o;
    logic [31:0] s8_a_i, s8_b_i, s8_diff_o;

    multi_cycle_sub #(.WIDTH(32), .SEG_W(8)) dut_s8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(s8_valid_i), .ready_o(s8_ready_o),
        .a_i(s8_a_i), .b_i(s8_b_i), .abs_i(s8_abs_i), .valid_o(s8_valid_o),
        .ready_i(s8_ready_i), .diff_o(s8_diff_o), .neg_o(s8_neg_o)
    );

    // WIDTH=48, SEG_W=16
    logic        w48_valid_i, w48_ready_o, w48_abs_i, w48_valid_o, w48_ready_i, w48_neg_o;
    logic [47:0] w48_a_i, w48_b_i, w48_diff_o;

    multi_cycle_sub #(.WIDTH(48), .SEG_W(16)) dut_w48 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(w48_valid_i), .ready_o(w48_ready_o),
        .a_i(w48_a_i), .b_i(w48_b_i), .abs_i(w48_abs_i), .valid_o(w48_valid_o),
        .ready_i(w48_ready_i), .diff_o(w48_diff_o), .neg_o(w48_neg_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands on the default instance and return once the accept edge has passed.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ab);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!ready_o) begin
            failures++;
            $display("FAIL start_op_ready: ready_o=%0b after %0d cycles, required 1", ready_o, n);
        end
        a_i = a; b_i = b; abs_i = ab; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        a_i = 32'h5A5A_A5A5; b_i = 32'hA5A5_5A5A; abs_i = ~ab;
    endtask

    // Cycles from the accept edge until valid_o is observed; -1 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!valid_o && lat < 40) begin
            tick();
            lat++;
        end
        if (!valid_o) lat = -1;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (valid_o !== 1'b0 || diff_o !== 32'h0 || neg_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid_o=%0b diff_o=%h neg_o=%0b, required 0/00000000/0",
                     valid_o, diff_o, neg_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready_o=%0b valid_o=%0b, required 1/0", ready_o, valid_o);
        end
    endtask

    task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic ab, input logic [31:0] exp_diff,
                                 input logic exp_neg, input int exp_lat);
        int lat;
        start_op(a, b, ab);
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: ready_o=%0b, required 0", name, ready_o);
        end
        wait_result(lat);
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (diff_o !== exp_diff || neg_o !== exp_neg) begin
            failures++;
            $display("FAIL %s_result: diff_o=%h neg_o=%0b, required %h/%0b",
                     name, diff_o, neg_o, exp_diff, exp_neg);
        end
        consume();
    endtask

    task automatic test_hold();
        int lat;
        start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; a_i = 32'h7; b_i = 32'h3; abs_i = 1'b0;
            tick();
            checks++;
            if (valid_o !== 1'b1 || diff_o !== 32'h0000_00FF || neg_o !== 1'b0 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid_o=%0b diff_o=%h neg_o=%0b ready_o=%0b, required 1/000000ff/0/0",
                         i, valid_o, diff_o, neg_o, ready_o);
            end
        end
        valid_i = 1'b0;
        consume();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: ready_o=%0b valid_o=%0b, required 1/0", ready_o, valid_o);
        end
        a_i = 32'h7; b_i = 32'h3; abs_i = 1'b0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_next_accept: ready_o=%0b, required 0", ready_o);
        end
        wait_result(lat);
        checks++;
        if (lat !== 2 || diff_o !== 32'h4 || neg_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_next_result: lat=%0d diff_o=%h neg_o=%0b, required 2/00000004/0",
                     lat, diff_o, neg_o);
        end
        consume();
    endtask

    task automatic test_reset_mid_neg();
        int strays;
        start_op(32'd5, 32'd9, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || diff_o !== 32'h0 || neg_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async: valid_o=%0b diff_o=%h neg_o=%0b ready_o=%0b, required 0/00000000/0/1",
                     valid_o, diff_o, neg_o, ready_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        strays = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_o !== 1'b0 || ready_o !== 1'b1) strays++;
        end
        checks++;
        if (strays != 0) begin
            failures++;
            $display("FAIL midreset_after: %0d cycles with valid_o!=0 or ready_o!=1, required 0", strays);
        end
    endtask

    // sel=0: WIDTH=32/SEG_W=8 (NSEG=4); sel=1: WIDTH=48/SEG_W=16 (NSEG=3).
    task automatic test_random(input int sel, input int nops);
        logic [63:0] r;
        logic [47:0] mask, a, b, exp_diff, got_diff;
        logic        ab, exp_neg, got_neg, vo;
        int          nseg, exp_lat, lat, stall;
        mask = sel ? 48'hFFFF_FFFF_FFFF : 48'h0000_FFFF_FFFF;
        nseg = sel ? 3 : 4;
        for (int n = 0; n < nops; n++) begin
            r = {$urandom, $urandom};
            a = r[47:0] & mask;
            r = {$urandom, $urandom};
            b = ($urandom_range(0, 7) == 0) ? a : (r[47:0] & mask);
            if ($urandom_range(0, 7) == 0) b = b & 48'hFF;
            ab = 1'($urandom_range(0, 1));
            exp_neg  = (a < b);
            exp_diff = (ab && exp_neg) ? ((b - a) & mask) : ((a - b) & mask);
            exp_lat  = (ab && exp_neg) ? 2 * nseg : nseg;
            if (sel == 1) begin
                w48_a_i = a; w48_b_i = b; w48_abs_i = ab; w48_valid_i = 1'b1;
            end else begin
                s8_a_i = a[31:0]; s8_b_i = b[31:0]; s8_abs_i = ab; s8_valid_i = 1'b1;
            end
            tick();
            w48_valid_i = 1'b0; s8_valid_i = 1'b0;
            w48_a_i = {16'h0, $urandom}; s8_a_i = $urandom; s8_abs_i = ~ab; w48_abs_i = ~ab;
            lat = 0;
            vo = sel ? w48_valid_o : s8_valid_o;
            while (!vo && lat < 40) begin
                tick();
                lat++;
                vo = sel ? w48_valid_o : s8_valid_o;
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            got_diff = sel ? w48_diff_o : {16'h0, s8_diff_o};
            got_neg  = sel ? w48_neg_o : s8_neg_o;
            checks++;
            if (!vo || lat != exp_lat) begin
                failures++;
                $display("FAIL rand%0d_latency op %0d: valid_o=%0b lat=%0d, required 1/%0d",
                         sel, n, vo, lat, exp_lat);
            end
            checks++;
            if (got_diff !== exp_diff || got_neg !== exp_neg) begin
                failures++;
                $display("FAIL rand%0d_result op %0d a=%h b=%h abs=%0b: diff_o=%h neg_o=%0b, required %h/%0b",
                         sel, n, a, b, ab, got_diff, got_neg, exp_diff, exp_neg);
            end
            if (sel == 1) w48_ready_i = 1'b1; else s8_ready_i = 1'b1;
            tick();
            w48_ready_i = 1'b0; s8_ready_i = 1'b0;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        valid_i = 0; a_i = 0; b_i = 0; abs_i = 0; ready_i = 0;
        s8_valid_i = 0; s8_a_i = 0; s8_b_i = 0; s8_abs_i = 0; s8_ready_i = 0;
        w48_valid_i = 0; w48_a_i = 0; w48_b_i = 0; w48_abs_i = 0; w48_ready_i = 0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_directed("borrow_seg", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 2);
        test_directed("neg_raw",    32'd5,         32'd9,         1'b0, 32'hFFFF_FFFC, 1'b1, 2);
        test_directed("neg_abs",    32'd5,         32'd9,         1'b1, 32'h0000_0004, 1'b1, 4);
        test_directed("abs_min",    32'h0,         32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 4);
        test_directed("equal",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 2);
        test_directed("pos_abs",    32'h1234_5678, 32'h0000_5679, 1'b1, 32'h1233_FFFF, 1'b0, 2);
        test_hold();
        test_reset_mid_neg();
        test_random(0, 2000);
        test_random(1, 2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
